fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, single-outstanding
// instruction-memory handshake, branch redirect with in-flight response drop,
// and a one-entry output buffer toward decode.
// Build option: define FETCH_BNE_EN to let branch_ne redirect fetch;
// without it only beq-style branches are taken.
module fetch_unit #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               br_valid,
    input  logic               branch_eq,
    input  logic               branch_ne,
    input  logic               zero,
    input  logic [PC_W-1:0]    br_pc,
    input  logic [PC_W-1:0]    br_offset,
    output logic [PC_W-1:0]    pc
);

    typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

    state_t            state;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pc_seq;

    // Branch resolution: taken decision and redirect target
`ifdef FETCH_BNE_EN
    assign taken = br_valid & ((branch_eq & zero) | (branch_ne & ~zero));
`else
    logic unused_branch_ne;
    assign unused_branch_ne = branch_ne;
    assign taken = br_valid & branch_eq & zero;
`endif

    assign target = br_pc + PC_W'(PC_STEP) + br_offset;
    assign pc_seq = pc + PC_W'(PC_STEP);

    // Fetch FSM with registered handshake, buffer and PC state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= PC_W'(RESET_PC);
            imem_req    <= 1'b0;
            imem_addr   <= PC_W'(RESET_PC);
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (taken) begin
                        pc <= target;
                    end else begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                REQ: begin
                    if (taken) begin
                        // A response arriving with the redirect is stale;
                        // without one, the outstanding request must be drained.
                        pc <= target;
                        if (imem_ack) begin
                            imem_addr <= target;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        pc          <= pc_seq;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                DROP: begin
                    if (taken) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= taken ? target : pc;
                    end
                end
                HOLD: begin
                    if (taken) begin
                        instr_valid <= 1'b0;
                        pc          <= target;
                        imem_req    <= 1'b1;
                        imem_addr   <= target;
                        state       <= REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                        state       <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder driven step by step,
// expected instructions queued at ack time and checked when decode sees them.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        br_valid;
    logic        branch_eq;
    logic        branch_ne;
    logic        zero;
    logic [7:0]  br_pc;
    logic [7:0]  br_offset;
    logic [7:0]  pc;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    fetch_unit #(
        .PC_W(8), .INSTR_W(32), .RESET_PC(0), .PC_STEP(1)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .br_valid(br_valid), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .zero(zero), .br_pc(br_pc), .br_offset(br_offset),
        .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {16'hC0DE, 8'h00, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_br();
        br_valid = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; zero = 1'b0;
        br_pc = 8'h00; br_offset = 8'h00;
    endtask

    task automatic drive_br(input logic eq, input logic ne, input logic z,
                            input logic [7:0] bpc, input logic [7:0] off);
        br_valid = 1'b1; branch_eq = eq; branch_ne = ne; zero = z;
        br_pc = bpc; br_offset = off;
    endtask

    // Wait (bounded) for a request, then check its address
    task automatic req_addr(input logic [7:0] a);
        int n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        check("imem_addr", 32'(imem_addr), 32'(a));
    endtask

    task automatic ack_push();
        exp_t e;
        e.pc   = imem_addr;
        e.data = mem_word(imem_addr);
        exp_q.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = e.data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic ack_junk();
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0000 | 32'(imem_addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic observe_pop();
        exp_t e;
        check("instr_valid", 32'(instr_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("instr_pc", 32'(instr_pc), 32'(e.pc));
            check("instr", instr, e.data);
        end
    endtask

    // One request: no ack on the first cycle, ack on the second
    task automatic fetch_one(input logic [7:0] a, input logic rdy);
        req_addr(a);
        instr_ready = rdy;
        check("bubble_valid", 32'(instr_valid), 32'd0);
        tick();
        ack_push();
        observe_pop();
    endtask

    initial begin
        int last;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b1;
        clear_br();

        // Asynchronous reset values before any clock edge
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        tick();
        reset = 1'b0;

        // Sequential fetch 0..3, valid every third cycle
        last = 0;
        for (int k = 0; k < 4; k++) begin
            fetch_one(8'(k), 1'b1);
            if (k > 0) check("valid_period", 32'(cyc - last), 32'd3);
            last = cyc;
        end

        // Taken beq before the ack: drain into DROP, then refetch at 3
        req_addr(8'h04);
        drive_br(1'b1, 1'b0, 1'b1, 8'h04, 8'hFE);
        tick();
        clear_br();
        check("drop_req", 32'(imem_req), 32'd1);
        check("drop_addr", 32'(imem_addr), 32'h04);
        check("drop_pc", 32'(pc), 32'h03);
        tick();
        check("drop_addr_hold", 32'(imem_addr), 32'h04);
        check("drop_valid", 32'(instr_valid), 32'd0);
        tick();
        ack_junk();
        check("after_drop_valid", 32'(instr_valid), 32'd0);
        check("after_drop_addr", 32'(imem_addr), 32'h03);
        fetch_one(8'h03, 1'b1);

        // Not-taken beq has no effect
        req_addr(8'h04);
        drive_br(1'b1, 1'b0, 1'b0, 8'h50, 8'h10);
        tick();
        clear_br();
        check("nt_pc", 32'(pc), 32'h04);
        check("nt_addr", 32'(imem_addr), 32'h04);

        // Taken together with ack: response discarded, refetch at 20
        drive_br(1'b1, 1'b0, 1'b1, 8'h0A, 8'h09);
        ack_junk();
        clear_br();
        check("tk_ack_valid", 32'(instr_valid), 32'd0);
        check("tk_ack_req", 32'(imem_req), 32'd1);
        check("tk_ack_addr", 32'(imem_addr), 32'd20);
        check("tk_ack_pc", 32'(pc), 32'd20);
        fetch_one(8'd20, 1'b1);

        // Backpressure: held instruction stays stable, then taken drops it
        fetch_one(8'd21, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr_pc", 32'(instr_pc), 32'd21);
            check("hold_instr", instr, mem_word(8'd21));
        end
        drive_br(1'b1, 1'b0, 1'b1, 8'hF0, 8'h0E);
        tick();
        clear_br();
        check("hold_tk_valid", 32'(instr_valid), 32'd0);
        check("hold_tk_pc", 32'(pc), 32'hFF);
        check("hold_tk_addr", 32'(imem_addr), 32'hFF);

        // Wrap from FF to 00
        fetch_one(8'hFF, 1'b1);
        check("pc_wrap", 32'(pc), 32'h00);
        fetch_one(8'h00, 1'b1);

        // bne with zero clear
        req_addr(8'h01);
        drive_br(1'b0, 1'b1, 1'b0, 8'h30, 8'h0F);
        tick();
        clear_br();
        check("bne_addr_hold", 32'(imem_addr), 32'h01);
`ifdef FETCH_BNE_EN
        check("bne_pc", 32'(pc), 32'h40);
        ack_junk();
        check("bne_valid", 32'(instr_valid), 32'd0);
        fetch_one(8'h40, 1'b1);
`else
        check("bne_pc", 32'(pc), 32'h01);
        ack_push();
        observe_pop();
`endif

        // Reset mid-transaction; ack while idle is ignored
        tick();
        check("pre_rst_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        imem_ack = 1'b1;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("idle_ack_valid", 32'(instr_valid), 32'd0);
        check("idle_ack_pc", 32'(pc), 32'd0);
        fetch_one(8'h00, 1'b1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
